// File: rtl/hw_io_pkg.sv
// Shared constants and state encoding for the pad-input conditioner.
// Imported by the per-channel debouncer and by the top level.
package hw_io_pkg;

    localparam int unsigned N_CH_DEF       = 32'd16;
    localparam int unsigned DEB_CYCLES_DEF = 32'd1000;
    localparam int unsigned CNT_W          = 32'd16;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } deb_state_e;

endpackage : hw_io_pkg

// File: rtl/hw_deb_channel.sv
// One conditioner channel: two-flop synchronizer followed by a debounce
// FSM that only commits a new level after DEB_CYCLES consecutive agreeing samples.
module hw_deb_channel
    import hw_io_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic        INIT_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic clean_out,
    output logic chg_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             s1_q;
    logic             s2_q;
    logic             clean_q;
    logic             clean_d;
    logic             pulse_q;
    logic             pulse_d;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State register; the synchronizer pair carries no logic between its flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= INIT_VAL;
            s2_q    <= INIT_VAL;
            clean_q <= INIT_VAL;
            pulse_q <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            s1_q    <= raw_in;
            s2_q    <= s1_q;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce next-state; the >= compare keeps the counter from ever wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        pulse_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2_q != clean_q) begin
                    state_d = QUALIFY;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            QUALIFY: begin
                if (s2_q == clean_q) begin
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_LAST) begin
                    clean_d = s2_q;
                    pulse_d = 1'b1;
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign clean_out = clean_q;
    assign chg_pulse = pulse_q;

endmodule : hw_deb_channel

// File: rtl/hw_input_conditioner.sv
// Top level: N_CH independent debounce channels plus sticky per-channel
// event latches (set beats acknowledge) and a registered any-event summary.
module hw_input_conditioner
    import hw_io_pkg::*;
#(
    parameter int unsigned      N_CH       = N_CH_DEF,
    parameter int unsigned      DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic [N_CH-1:0]  INIT_VAL   = {N_CH{1'b1}}
) (
    input  logic            CLK_100M,
    input  logic            RST,
    input  logic [N_CH-1:0] RAW_IN,
    input  logic [N_CH-1:0] EVT_ACK,
    output logic [N_CH-1:0] CLEAN_OUT,
    output logic [N_CH-1:0] CHG_PULSE,
    output logic [N_CH-1:0] EVT_LATCH,
    output logic            EVT_ANY
);

    logic [N_CH-1:0] evt_latch_q;
    logic [N_CH-1:0] evt_latch_d;
    logic            evt_any_q;
    logic            evt_any_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        hw_deb_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .INIT_VAL   (INIT_VAL[i])
        ) u_ch (
            .clk       (CLK_100M),
            .rst       (RST),
            .raw_in    (RAW_IN[i]),
            .clean_out (CLEAN_OUT[i]),
            .chg_pulse (CHG_PULSE[i])
        );
    end

    // A new transition re-arms the latch even if it is being acknowledged that cycle.
    always_comb begin
        evt_latch_d = (evt_latch_q & ~EVT_ACK) | CHG_PULSE;
        evt_any_d   = |evt_latch_q;
    end

    // Event latch and summary registers.
    always_ff @(posedge CLK_100M) begin
        if (RST) begin
            evt_latch_q <= {N_CH{1'b0}};
            evt_any_q   <= 1'b0;
        end else begin
            evt_latch_q <= evt_latch_d;
            evt_any_q   <= evt_any_d;
        end
    end

    assign EVT_LATCH = evt_latch_q;
    assign EVT_ANY   = evt_any_q;

endmodule : hw_input_conditioner

// File: tb/tb_hw_input_conditioner.sv
// Directed self-checking bench for hw_input_conditioner (4 channels, 8-clock debounce).
module tb_hw_input_conditioner;

    localparam int N   = 4;
    localparam int DEB = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] ack;
    logic [N-1:0] clean;
    logic [N-1:0] pulse;
    logic [N-1:0] latch;
    logic         any;

    int           n_chk = 0;
    int           n_pass = 0;
    int           pulse_cnt [N];
    bit           mon_en = 1'b0;
    logic         rst_prev = 1'b1;
    logic [N-1:0] clean_prev;

    always #5 clk = ~clk;

    hw_input_conditioner #(
        .N_CH       (N),
        .DEB_CYCLES (DEB),
        .INIT_VAL   (4'b1111)
    ) dut (
        .CLK_100M  (clk),
        .RST       (rst),
        .RAW_IN    (raw),
        .EVT_ACK   (ack),
        .CLEAN_OUT (clean),
        .CHG_PULSE (pulse),
        .EVT_LATCH (latch),
        .EVT_ANY   (any)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < N; i++) s += pulse_cnt[i];
        return s;
    endfunction

    // Every non-reset cycle: CLEAN_OUT may only move together with CHG_PULSE.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_prev) chk("clean_chg_without_pulse", 32'((clean ^ clean_prev) & ~pulse), 32'd0);
            for (int i = 0; i < N; i++) if (pulse[i] === 1'b1) pulse_cnt[i]++;
        end
        rst_prev   = rst;
        clean_prev = clean;
    end

    initial begin
        int base;
        int base1;
        int rem [N];
        logic [N-1:0] lvl;
        logic [N-1:0] v;

        for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
        rst = 1'b1;
        raw = 4'hF;
        ack = 4'h0;
        step(3);
        chk("rst_clean", 32'(clean), 32'hF);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_latch", 32'(latch), 32'h0);
        chk("rst_any",   32'(any),   32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);
        chk("idle_clean", 32'(clean), 32'hF);
        chk("idle_pulse", 32'(pulse), 32'h0);

        // Clean edge on channel 0
        base = pulse_cnt[0];
        raw = 4'hE;
        step(DEB + 1);
        chk("edge_clean_before", 32'(clean), 32'hF);
        step(1);
        chk("edge_clean_fall", 32'(clean), 32'hE);
        chk("edge_pulse", 32'(pulse), 32'h1);
        step(1);
        chk("edge_pulse_gone", 32'(pulse), 32'h0);
        chk("edge_latch", 32'(latch), 32'h1);
        chk("edge_any_delay", 32'(any), 32'h0);
        step(1);
        chk("edge_any", 32'(any), 32'h1);
        step(8);
        chk("edge_pulse_count", 32'(pulse_cnt[0] - base), 32'd1);

        // Lone ack, then ack on an empty latch
        ack = 4'h1;
        step(1);
        ack = 4'h0;
        chk("ack_clear", 32'(latch), 32'h0);
        chk("ack_any_hold", 32'(any), 32'h1);
        step(1);
        chk("ack_any_clear", 32'(any), 32'h0);
        ack = 4'h2;
        step(1);
        ack = 4'h0;
        chk("ack_empty", 32'(latch), 32'h0);

        // Ack collides with the set
        raw = 4'hF;
        step(DEB + 2);
        chk("coll_clean_rise", 32'(clean), 32'hF);
        chk("coll_pulse", 32'(pulse), 32'h1);
        ack = 4'h1;
        step(1);
        ack = 4'h0;
        chk("coll_set_wins", 32'(latch), 32'h1);
        step(1);
        chk("coll_latch_hold", 32'(latch), 32'h1);
        chk("coll_any", 32'(any), 32'h1);
        ack = 4'h1;
        step(1);
        ack = 4'h0;
        chk("coll_ack_clear", 32'(latch), 32'h0);
        step(1);
        chk("coll_any_clear", 32'(any), 32'h0);

        // Bounce on channel 1: 7 low, 1 high, then held low
        base = pulse_cnt[1];
        raw = 4'hD;
        step(7);
        raw = 4'hF;
        step(1);
        raw = 4'hD;
        for (int j = 0; j < DEB + 1; j++) begin
            step(1);
            chk("bounce_hold", 32'(clean[1]), 32'd1);
        end
        step(1);
        chk("bounce_clean_fall", 32'(clean), 32'hD);
        chk("bounce_pulse", 32'(pulse), 32'h2);
        step(10);
        chk("bounce_pulse_count", 32'(pulse_cnt[1] - base), 32'd1);

        // Reset at counter=5 (ch2 qualifying low, ch1 qualifying high)
        base  = pulse_cnt[2];
        base1 = pulse_cnt[1];
        raw = 4'hB;
        step(7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_clean", 32'(clean), 32'hF);
        chk("mid_rst_pulse", 32'(pulse), 32'h0);
        chk("mid_rst_latch", 32'(latch), 32'h0);
        chk("mid_rst_any",   32'(any),   32'h0);
        step(DEB + 1);
        chk("post_rst_before", 32'(clean[2]), 32'd1);
        chk("post_rst_no_pulse2", 32'(pulse_cnt[2] - base), 32'd0);
        chk("post_rst_no_pulse1", 32'(pulse_cnt[1] - base1), 32'd0);
        step(1);
        chk("post_rst_fall", 32'(clean), 32'hB);
        chk("post_rst_pulse", 32'(pulse), 32'h4);

        // All channels fall together
        raw = 4'hF;
        step(12);
        ack = 4'hF;
        step(1);
        ack = 4'h0;
        step(1);
        chk("multi_pre_latch", 32'(latch), 32'h0);
        chk("multi_pre_any", 32'(any), 32'h0);
        raw = 4'h0;
        step(DEB + 1);
        chk("multi_before", 32'(clean), 32'hF);
        step(1);
        chk("multi_fall", 32'(clean), 32'h0);
        chk("multi_pulse", 32'(pulse), 32'hF);
        step(1);
        chk("multi_pulse_gone", 32'(pulse), 32'h0);
        chk("multi_latch", 32'(latch), 32'hF);
        step(1);
        chk("multi_any", 32'(any), 32'h1);

        // Glitch soak: high runs of 1..7 clocks separated by low runs
        base = total_pulses();
        lvl = 4'h0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = int'($urandom_range(1, DEB - 1));
                end
                rem[i]--;
            end
            v = lvl;
            raw = v;
            step(1);
        end
        raw = 4'h0;
        step(12);
        chk("soak_no_pulse", 32'(total_pulses() - base), 32'd0);
        chk("soak_clean", 32'(clean), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_hw_input_conditioner
